pwr_good_monitor: RTL

Board power-rail readback and supervision block for the PCB I/O debug design. It sits beside the switch-driven rail enables and consumes the regulators' asynchronous power-good (PG) returns. Each rail's PG is synchronized and debounced, then checked against that rail's effective enable. Ramp timeouts and PG drops are reported as sticky faults, which optionally force all rails off.

---
 rtl/pwr_pkg.sv | 33 +++
 rtl/pg_rail_fsm.sv | 124 ++++++++++++
 rtl/pwr_good_monitor.sv | 78 +++++++
 3 files changed

// File: rtl/pwr_pkg.sv
// Shared types and constants for the board power-rail supervisor (pwr_good_monitor).
// Rail order matches the board enable switches: VDD2, AVDD1_ESD, AVDD1, DVDD1, VREF.
package pwr_pkg;

    localparam int NUM_RAILS_DEFAULT = 5;

    typedef enum logic [2:0] {
        RAIL_VDD2      = 3'd0,
        RAIL_AVDD1_ESD = 3'd1,
        RAIL_AVDD1     = 3'd2,
        RAIL_DVDD1     = 3'd3,
        RAIL_VREF      = 3'd4
    } rail_idx_t;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RAMP  = 2'd1,
        GOOD  = 2'd2,
        FAULT = 2'd3
    } rail_state_t;

    typedef enum logic [1:0] {
        FT_NONE    = 2'd0,
        FT_TIMEOUT = 2'd1,
        FT_DROP    = 2'd2
    } fault_type_t;

    // Bits needed for a counter that runs 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pg_rail_fsm.sv
// One supervised rail: PG synchronizer, debouncer, ramp timer and OFF/RAMP/GOOD/FAULT FSM.
// The FSM state and latched fault type are exported so the top can decode outputs from them.
module pg_rail_fsm
    import pwr_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 1000,
    parameter int RAMP_TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pg_async,
    input  logic        fault_clr,
    output rail_state_t state,
    output fault_type_t fault_type
);

    localparam int DW = cnt_width(DEBOUNCE_CYC);
    localparam int TW = cnt_width(RAMP_TIMEOUT_CYC);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(RAMP_TIMEOUT_CYC - 1);

    logic          pg_meta;
    logic          pg_sync;
    logic          pg_stable;
    logic [DW-1:0] db_cnt;

    rail_state_t   state_q;
    rail_state_t   state_d;
    fault_type_t   type_q;
    fault_type_t   type_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pg_meta <= 1'b0;
            pg_sync <= 1'b0;
        end else begin
            pg_meta <= pg_async;
            pg_sync <= pg_meta;
        end
    end

    // A new PG level is accepted only after it has differed from the stable one
    // for DEBOUNCE_CYC consecutive cycles; any return to the stable level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pg_stable <= 1'b0;
            db_cnt    <= '0;
        end else if (pg_sync == pg_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            pg_stable <= ~pg_stable;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            type_q  <= FT_NONE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            timer_q <= timer_d;
        end
    end

    // Enable removal is tested first in RAMP and GOOD so a disable racing a PG drop
    // lands in OFF; PG good is tested before the timeout so a late-but-good rail wins.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        timer_d = timer_q;
        unique case (state_q)
            OFF: begin
                if (en) begin
                    state_d = RAMP;
                    timer_d = '0;
                end
            end
            RAMP: begin
                if (!en) begin
                    state_d = OFF;
                end else if (pg_stable) begin
                    state_d = GOOD;
                end else if (timer_q == TO_LAST) begin
                    state_d = FAULT;
                    type_d  = FT_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GOOD: begin
                if (!en) begin
                    state_d = OFF;
                end else if (!pg_stable) begin
                    state_d = FAULT;
                    type_d  = FT_DROP;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = OFF;
                    type_d  = FT_NONE;
                end
            end
            default: begin
                state_d = OFF;
                type_d  = FT_NONE;
            end
        endcase
    end

    always_comb begin
        state      = state_q;
        fault_type = type_q;
    end

endmodule

// File: rtl/pwr_good_monitor.sv
// Board power-rail supervisor: NUM_RAILS pg_rail_fsm instances plus fault OR and global shutdown.
// Define PWR_GOOD_MONITOR_AUTO_SHUTDOWN_EN to make any fault force all rails off until cleared.
module pwr_good_monitor
    import pwr_pkg::*;
#(
    parameter int NUM_RAILS        = NUM_RAILS_DEFAULT,
    parameter int DEBOUNCE_CYC     = 1000,
    parameter int RAMP_TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RAILS-1:0] en_req,
    input  logic [NUM_RAILS-1:0] pg_in,
    input  logic                 fault_clr,
    output logic [NUM_RAILS-1:0] en_out,
    output logic [NUM_RAILS-1:0] rail_good,
    output logic [NUM_RAILS-1:0] fault_timeout,
    output logic [NUM_RAILS-1:0] fault_drop,
    output logic                 fault_any,
    output logic                 shutdown
);

    rail_state_t          rail_state [NUM_RAILS];
    fault_type_t          rail_fault [NUM_RAILS];
    logic [NUM_RAILS-1:0] fault_bits;
    logic                 fault_any_q;

    generate
        for (genvar i = 0; i < NUM_RAILS; i++) begin : g_rail
            pg_rail_fsm #(
                .DEBOUNCE_CYC     (DEBOUNCE_CYC),
                .RAMP_TIMEOUT_CYC (RAMP_TIMEOUT_CYC)
            ) u_rail (
                .clk        (clk),
                .rst        (rst),
                .en         (en_out[i]),
                .pg_async   (pg_in[i]),
                .fault_clr  (fault_clr),
                .state      (rail_state[i]),
                .fault_type (rail_fault[i])
            );
        end
    endgenerate

    always_comb begin
        rail_good     = '0;
        fault_timeout = '0;
        fault_drop    = '0;
        for (int i = 0; i < NUM_RAILS; i++) begin
            rail_good[i]     = (rail_state[i] == GOOD);
            fault_timeout[i] = (rail_state[i] == FAULT) && (rail_fault[i] == FT_TIMEOUT);
            fault_drop[i]    = (rail_state[i] == FAULT) && (rail_fault[i] == FT_DROP);
        end
    end

    assign fault_bits = fault_timeout | fault_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_any_q <= 1'b0;
        end else begin
            fault_any_q <= |fault_bits;
        end
    end

    assign fault_any = fault_any_q;

    // The shutdown flop is the registered fault OR: it rises one cycle after a rail
    // faults and falls one cycle after fault_clr empties every FAULT state.
`ifdef PWR_GOOD_MONITOR_AUTO_SHUTDOWN_EN
    assign shutdown = fault_any_q;
`else
    assign shutdown = 1'b0;
`endif

    assign en_out = en_req & ~{NUM_RAILS{shutdown}};

endmodule
